bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter using reverse double dabble (shift right, subtract-3 correction). Converts a 3-digit packed BCD value into a 10-bit binary value over a fixed number of clock cycles. It sits on the input side of the game datapath and turns player-entered or stored decimal digits back into a binary value for comparison against game numbers. It is the inverse of the combinational binary-to-BCD converter used on the display path.

---
 rtl/bcd_to_bin_seq_if.sv | 33 +++
 rtl/bcd_to_bin_seq.sv | 107 ++++++++++
 tb/tb_bcd_to_bin_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_seq_if.sv
// rtl/bcd_to_bin_seq_if.sv - request/result bundle for the sequential BCD-to-binary converter
interface bcd_to_bin_seq_if #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
);
   logic                  start;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  busy;
   logic                  done;
   logic [BIN_W-1:0]      bin_out;
   logic                  err;
   logic                  ovf;

   modport master (
      output start,
      output bcd_in,
      input  busy,
      input  done,
      input  bin_out,
      input  err,
      input  ovf
   );

   modport slave (
      input  start,
      input  bcd_in,
      output busy,
      output done,
      output bin_out,
      output err,
      output ovf
   );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - reverse double dabble BCD-to-binary converter, one bit per clock
module bcd_to_bin_seq #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_to_bin_seq_if.slave   bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);
   localparam logic [BIN_W-1:0] GAME_MAX = BIN_W'(255);

   typedef enum logic {
      IDLE,
      CONV
   } state_t;

   state_t            state;
   logic [SR_W-1:0]   sreg;
   logic [3:0]        iter;
   logic              busy_q;
   logic              done_q;
   logic [BIN_W-1:0]  bin_q;
   logic              err_q;
   logic              ovf_q;

   logic [SR_W-1:0]   shifted;
   logic [SR_W-1:0]   corrected;
   logic              digit_bad;

   // One iteration: shift right, then pull each BCD nibble that reached >= 8 back by 3.
   always_comb begin
      shifted   = sreg >> 1;
      corrected = shifted;
      for (int i = 0; i < DIGITS; i++) begin
         if (shifted[BIN_W+4*i +: 4] >= 4'd8) begin
            corrected[BIN_W+4*i +: 4] = shifted[BIN_W+4*i +: 4] - 4'd3;
         end
      end
   end

   always_comb begin
      digit_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.bcd_in[4*i +: 4] > 4'd9) begin
            digit_bad = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sreg   <= '0;
         iter   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         bin_q  <= '0;
         err_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (digit_bad) begin
                     // Bad digits are reported at once without entering CONV.
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                     bin_q  <= '0;
                     ovf_q  <= 1'b0;
                  end else begin
                     sreg   <= {bus.bcd_in, {BIN_W{1'b0}}};
                     iter   <= '0;
                     busy_q <= 1'b1;
                     state  <= CONV;
                  end
               end
            end
            CONV: begin
               sreg <= corrected;
               iter <= iter + 4'd1;
               if (iter == LAST_ITER) begin
                  bin_q  <= corrected[BIN_W-1:0];
                  err_q  <= 1'b0;
                  ovf_q  <= (corrected[BIN_W-1:0] > GAME_MAX);
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.bin_out = bin_q;
   assign bus.err     = err_q;
   assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - directed self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

   bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after the accept edge; poke>0 re-asserts start with 12'h777 on that cycle.
   task automatic wait_done(input string tag, input logic [9:0] exp_bin, input logic exp_ovf, input int poke);
      int n;
      check({tag, "_busy_after_accept"}, 16'(bus.busy), 16'd1);
      n = 0;
      while (!bus.done && n < 20) begin
         if (poke > 0 && n == poke) begin
            bus.start  = 1'b1;
            bus.bcd_in = 12'h777;
         end else begin
            bus.start  = 1'b0;
            bus.bcd_in = 12'h000;
         end
         tick();
         n++;
         if (!bus.done && n < 10) check({tag, "_busy_hold"}, 16'(bus.busy), 16'd1);
      end
      bus.start = 1'b0;
      check({tag, "_latency"}, 16'(n), 16'd10);
      check({tag, "_done"}, 16'(bus.done), 16'd1);
      check({tag, "_busy_end"}, 16'(bus.busy), 16'd0);
      check({tag, "_bin"}, 16'(bus.bin_out), 16'(exp_bin));
      check({tag, "_ovf"}, 16'(bus.ovf), 16'(exp_ovf));
      check({tag, "_err"}, 16'(bus.err), 16'd0);
   endtask

   task automatic accept(input logic [11:0] bcd);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bcd_in = bcd;
      tick();
      bus.start  = 1'b0;
   endtask

   task automatic run_conv(input string tag, input logic [11:0] bcd, input logic [9:0] exp_bin, input logic exp_ovf);
      accept(bcd);
      wait_done(tag, exp_bin, exp_ovf, 0);
      tick();
      check({tag, "_done_single"}, 16'(bus.done), 16'd0);
      check({tag, "_bin_hold"}, 16'(bus.bin_out), 16'(exp_bin));
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.bcd_in = 12'h000;
      tick();
      tick();
      check("rst_busy", 16'(bus.busy), 16'd0);
      check("rst_done", 16'(bus.done), 16'd0);
      check("rst_bin", 16'(bus.bin_out), 16'd0);
      check("rst_err", 16'(bus.err), 16'd0);
      check("rst_ovf", 16'(bus.ovf), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      run_conv("c255", 12'h255, 10'd255, 1'b0);
      run_conv("c256", 12'h256, 10'd256, 1'b1);
      run_conv("c999", 12'h999, 10'h3E7, 1'b1);

      // Invalid tens digit: reported on the sampling edge, prior result overwritten.
      accept(12'h1A5);
      check("bad_done", 16'(bus.done), 16'd1);
      check("bad_err", 16'(bus.err), 16'd1);
      check("bad_bin", 16'(bus.bin_out), 16'd0);
      check("bad_ovf", 16'(bus.ovf), 16'd0);
      check("bad_busy", 16'(bus.busy), 16'd0);
      tick();
      check("bad_done_single", 16'(bus.done), 16'd0);
      check("bad_busy_after", 16'(bus.busy), 16'd0);
      check("bad_err_hold", 16'(bus.err), 16'd1);

      run_conv("c000", 12'h000, 10'd0, 1'b0);

      // Back-to-back: the second start is presented during the first done cycle.
      accept(12'h128);
      wait_done("b2b_a", 10'd128, 1'b0, 0);
      bus.start  = 1'b1;
      bus.bcd_in = 12'h042;
      tick();
      bus.start  = 1'b0;
      check("b2b_b_done_low", 16'(bus.done), 16'd0);
      wait_done("b2b_b", 10'd42, 1'b0, 0);
      tick();

      // start and bcd_in disturbed mid-conversion.
      accept(12'h321);
      wait_done("ign", 10'd321, 1'b1, 4);
      tick();
      check("ign_idle", 16'(bus.busy), 16'd0);

      // Asynchronous reset at iteration 5.
      accept(12'h500);
      for (int i = 0; i < 5; i++) tick();
      check("abort_busy_before", 16'(bus.busy), 16'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 16'(bus.busy), 16'd0);
      check("abort_bin", 16'(bus.bin_out), 16'd0);
      check("abort_ovf", 16'(bus.ovf), 16'd0);
      check("abort_done", 16'(bus.done), 16'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("abort_no_done", 16'(bus.done), 16'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("abort_still_idle", 16'(bus.busy), 16'd0);
      run_conv("c100", 12'h100, 10'd100, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
